int_service_ctrl: RTL and testbench

- Sequencer for the 4-input hardware vectored priority interrupt system (int/mask registers, priority encoder, isrAddr/intPending).
- Owns all of that block's load/clear/disable controls: periodically samples interrupt lines, evaluates pending status and raises a CPU request.
- On CPU acknowledge, captures the vector and holds it while the ISR runs; on return-from-interrupt, clears the serviced state.
- Also serialises CPU mask writes into the mask register.

---
 rtl/int_service_ctrl.sv | 173 +++++++++++++++++
 tb/tb_int_service_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_service_ctrl.sv
// rtl/int_service_ctrl.sv - sequencer for the 4-input vectored priority interrupt system
// Drives the load/clear/disable strobes, raises irq, captures the vector and serialises mask writes.
module int_service_ctrl #(
    parameter int SAMPLE_DIV  = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int VEC_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             intPendingIn,
    input  logic [VEC_W-1:0] isrAddrIn,
    input  logic             irqAck,
    input  logic             iret,
    input  logic             maskWr,
    input  logic [3:0]       maskData,
    input  logic             globalEn,
    output logic             ldIntReg,
    output logic             clrIntReg,
    output logic             ldMask,
    output logic             clrMask,
    output logic [3:0]       intMask,
    output logic             clrPend,
    output logic             intDisable,
    output logic             irq,
    output logic [VEC_W-1:0] isrVector,
    output logic             inService
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_EVAL, S_REQ, S_SERVICE, S_CLEAR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [8:0] TMO_LIM  = 9'(ACK_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic [7:0]       tmo_q, tmo_d;
    logic             eval_q, eval_d;
    logic             ldint_q, ldint_d;
    logic             ldmask_q, ldmask_d;
    logic [3:0]       mask_q, mask_d;
    logic             clrint_q, clrint_d;
    logic             clrmask_q, clrmask_d;
    logic             clrpend_q, clrpend_d;
    logic             intdis_q, intdis_d;
    logic             irq_q, irq_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             insvc_q, insvc_d;

    // The sample counter keeps running through EVAL so the sampling period stays SAMPLE_DIV.
    assign cnt_inc = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = 8'd0;
        eval_d    = 1'b0;
        ldmask_d  = 1'b0;
        mask_d    = mask_q;
        clrint_d  = 1'b1;
        clrmask_d = 1'b1;
        clrpend_d = 1'b1;
        intdis_d  = ~globalEn;
        irq_d     = 1'b0;
        vec_d     = vec_q;
        insvc_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            S_IDLE: begin
                if (globalEn) cnt_d = cnt_inc;
                if (ldint_q) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (globalEn) cnt_d = cnt_inc;
                eval_d = ~eval_q;
                if (eval_q) begin
                    if (intPendingIn) begin
                        state_d = S_REQ;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_REQ: begin
                if (irqAck) begin
                    state_d  = S_SERVICE;
                    vec_d    = isrAddrIn;
                    insvc_d  = 1'b1;
                    intdis_d = 1'b1;
                end else if (!globalEn || ({1'b0, tmo_q} + 9'd1 == TMO_LIM)) begin
                    state_d   = S_IDLE;
                    clrpend_d = 1'b0;
                end else begin
                    irq_d = 1'b1;
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_SERVICE: begin
                insvc_d  = 1'b1;
                intdis_d = 1'b1;
                if (iret) begin
                    state_d   = S_CLEAR;
                    insvc_d   = 1'b0;
                    clrint_d  = 1'b0;
                    clrpend_d = 1'b0;
                    vec_d     = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: state_d = S_INIT;
        endcase
        if (state_q != S_INIT && maskWr) begin
            ldmask_d = 1'b1;
            mask_d   = maskData;
        end
        // Decided one cycle ahead so ldIntReg is a registered output.
        ldint_d = (state_d == S_IDLE) && (cnt_d == CNT_LAST) && globalEn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            cnt_q     <= 8'd0;
            tmo_q     <= 8'd0;
            eval_q    <= 1'b0;
            ldint_q   <= 1'b0;
            ldmask_q  <= 1'b0;
            mask_q    <= 4'd0;
            clrint_q  <= 1'b0;
            clrmask_q <= 1'b0;
            clrpend_q <= 1'b0;
            intdis_q  <= 1'b1;
            irq_q     <= 1'b0;
            vec_q     <= '0;
            insvc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            eval_q    <= eval_d;
            ldint_q   <= ldint_d;
            ldmask_q  <= ldmask_d;
            mask_q    <= mask_d;
            clrint_q  <= clrint_d;
            clrmask_q <= clrmask_d;
            clrpend_q <= clrpend_d;
            intdis_q  <= intdis_d;
            irq_q     <= irq_d;
            vec_q     <= vec_d;
            insvc_q   <= insvc_d;
        end
    end

    assign ldIntReg   = ldint_q;
    assign clrIntReg  = clrint_q;
    assign ldMask     = ldmask_q;
    assign clrMask    = clrmask_q;
    assign intMask    = mask_q;
    assign clrPend    = clrpend_q;
    assign intDisable = intdis_q;
    assign irq        = irq_q;
    assign isrVector  = vec_q;
    assign inService  = insvc_q;

endmodule

// File: tb/tb_int_service_ctrl.sv
// tb/tb_int_service_ctrl.sv - scoreboard bench for int_service_ctrl with a modelled interrupt system
module tb_int_service_ctrl;

    localparam int DIV = 4;
    localparam int TO  = 16;
    localparam int VW  = 16;

    localparam int M_INIT = 0, M_IDLE = 1, M_EVAL = 2, M_REQ = 3, M_SERVICE = 4, M_CLEAR = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          intPendingIn;
    logic [VW-1:0] isrAddrIn;
    logic          irqAck, iret, maskWr, globalEn;
    logic [3:0]    maskData;
    logic          ldIntReg, clrIntReg, ldMask, clrMask, clrPend, intDisable, irq, inService;
    logic [3:0]    intMask;
    logic [VW-1:0] isrVector;
    logic [3:0]    lines;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_service_ctrl #(.SAMPLE_DIV(DIV), .ACK_TIMEOUT(TO), .VEC_W(VW)) dut (
        .clk(clk), .rst(rst), .intPendingIn(intPendingIn), .isrAddrIn(isrAddrIn),
        .irqAck(irqAck), .iret(iret), .maskWr(maskWr), .maskData(maskData),
        .globalEn(globalEn), .ldIntReg(ldIntReg), .clrIntReg(clrIntReg),
        .ldMask(ldMask), .clrMask(clrMask), .intMask(intMask), .clrPend(clrPend),
        .intDisable(intDisable), .irq(irq), .isrVector(isrVector), .inService(inService)
    );

    function automatic logic [VW-1:0] prio(input logic [3:0] v);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) if (v[i]) r = VW'(i + 1);
        return r;
    endfunction

    // Interrupt system attached to the DUT
    logic [3:0] e_int, e_mask;
    logic       e_pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_int  <= 4'd0;
            e_mask <= 4'd0;
            e_pend <= 1'b0;
        end else begin
            if (!clrIntReg) e_int <= 4'd0; else if (ldIntReg) e_int <= lines;
            if (!clrMask) e_mask <= 4'd0; else if (ldMask) e_mask <= intMask;
            if (!clrPend) e_pend <= 1'b0; else if (!intDisable) e_pend <= |(e_int & e_mask);
        end
    end
    assign intPendingIn = e_pend;
    assign isrAddrIn    = prio(e_int & e_mask);

    typedef struct packed {
        logic          ld, ldm, ci, cm, cp, dis, irq, ins;
        logic [3:0]    mask;
        logic [VW-1:0] vec;
    } outs_t;

    outs_t exp_q[$];
    outs_t m;
    int    phase, pos, evals, waited;
    logic [3:0] m_int, m_maskr;
    logic       m_pend;

    task automatic model_reset();
        m = '0;
        m.dis = 1'b1;
        phase = M_INIT; pos = 0; evals = 0; waited = 0;
        m_int = 4'd0; m_maskr = 4'd0; m_pend = 1'b0;
    endtask

    task automatic model_step();
        outs_t n;
        logic [VW-1:0] addr;
        logic [3:0] nint, nmask;
        logic npend;
        addr = prio(m_int & m_maskr);
        n = m;
        n.ld = 0; n.ldm = 0; n.irq = 0; n.ins = 0;
        n.ci = 1; n.cm = 1; n.cp = 1; n.dis = !globalEn;
        if (phase != M_INIT && maskWr) begin n.ldm = 1; n.mask = maskData; end
        case (phase)
            M_INIT: begin phase = M_IDLE; pos = 0; end
            M_IDLE: begin
                if (globalEn) pos = (pos + 1) % DIV;
                if (m.ld) begin phase = M_EVAL; evals = 0; end
            end
            M_EVAL: begin
                if (globalEn) pos = (pos + 1) % DIV;
                evals++;
                if (evals == 2) begin
                    if (m_pend) begin phase = M_REQ; n.irq = 1; waited = 0; end
                    else phase = M_IDLE;
                end
            end
            M_REQ: begin
                waited++;
                if (irqAck) begin
                    phase = M_SERVICE; n.vec = addr; n.ins = 1; n.dis = 1;
                end else if (!globalEn || waited == TO) begin
                    phase = M_IDLE; n.cp = 0;
                end else n.irq = 1;
            end
            M_SERVICE: begin
                n.ins = 1; n.dis = 1;
                if (iret) begin
                    phase = M_CLEAR; n.ins = 0; n.ci = 0; n.cp = 0; n.vec = '0;
                end
            end
            default: begin phase = M_IDLE; pos = 0; end
        endcase
        n.ld = (phase == M_IDLE) && (pos == DIV - 1) && globalEn;
        nint  = !m.ci ? 4'd0 : (m.ld ? lines : m_int);
        nmask = !m.cm ? 4'd0 : (m.ldm ? m.mask : m_maskr);
        npend = !m.cp ? 1'b0 : (!m.dis ? |(m_int & m_maskr) : m_pend);
        m_int = nint; m_maskr = nmask; m_pend = npend;
        m = n;
        exp_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic wait_irq(input int limit);
        int n = 0;
        while (!irq && n < limit) begin tick(); n++; end
        chk("irq_wait", 32'(irq), 32'd1);
    endtask

    outs_t mon_e, mon_a;
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {ldIntReg, ldMask, clrIntReg, clrMask, clrPend, intDisable, irq, inService,
                     intMask, isrVector};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL scoreboard @%0t: got %h expected %h", $time, mon_a, mon_e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic seen_irq;
        rst = 1; irqAck = 0; iret = 0; maskWr = 0; maskData = 0; globalEn = 1; lines = 0;
        model_reset();
        #2;
        chk("rst_irq", 32'(irq), 0);
        chk("rst_clrIntReg", 32'(clrIntReg), 0);
        chk("rst_clrPend", 32'(clrPend), 0);
        chk("rst_intDisable", 32'(intDisable), 1);
        chk("rst_ldIntReg", 32'(ldIntReg), 0);
        @(posedge clk); #1;
        rst = 0;
        chk("init_clear_held", 32'(clrIntReg), 0);
        maskWr = 1; maskData = 4'hf;
        tick();
        maskWr = 0;
        chk("init_mask_dropped", 32'(ldMask), 0);
        chk("idle_clrIntReg", 32'(clrIntReg), 1);
        chk("idle_clrMask", 32'(clrMask), 1);

        c = 0; seen_irq = 0;
        for (int i = 0; i < 16; i++) begin
            if (ldIntReg) c++;
            if (irq) seen_irq = 1;
            tick();
        end
        chk("ld_period", 32'(c), 4);
        chk("no_irq_idle", 32'(seen_irq), 0);

        maskData = 4'b0110; maskWr = 1;
        tick();
        maskWr = 0;
        chk("ldMask_pulse", 32'(ldMask), 1);
        chk("intMask_val", 32'(intMask), 32'h6);
        lines = 4'b0110;
        wait_irq(40);
        irqAck = 1; tick(); irqAck = 0;
        chk("vec_line1", 32'(isrVector), 2);
        chk("in_service", 32'(inService), 1);
        chk("svc_disable", 32'(intDisable), 1);

        lines = 4'b0100;
        repeat (3) tick();
        irqAck = 1; tick(); irqAck = 0;
        iret = 1; tick(); iret = 0;
        chk("clear_clrIntReg", 32'(clrIntReg), 0);
        chk("clear_clrPend", 32'(clrPend), 0);
        chk("clear_vector", 32'(isrVector), 0);
        wait_irq(40);
        irqAck = 1; tick(); irqAck = 0;
        chk("vec_line2", 32'(isrVector), 3);

        iret = 1; tick(); iret = 0;
        wait_irq(40);
        c = 0;
        while (irq && c < 40) begin c++; tick(); end
        chk("timeout_len", 32'(c), TO);
        chk("timeout_clrPend", 32'(clrPend), 0);
        wait_irq(40);

        globalEn = 0;
        tick();
        chk("gen_off_irq", 32'(irq), 0);
        chk("gen_off_clrPend", 32'(clrPend), 0);
        c = 0;
        repeat (12) begin tick(); if (ldIntReg) c++; end
        chk("gen_off_no_ld", 32'(c), 0);
        chk("gen_off_disable", 32'(intDisable), 1);
        globalEn = 1;
        wait_irq(40);
        irqAck = 1; tick(); irqAck = 0;
        tick();
        chk("svc_before_rst", 32'(inService), 1);

        #3 rst = 1;
        #1;
        chk("async_irq", 32'(irq), 0);
        chk("async_inService", 32'(inService), 0);
        chk("async_vector", 32'(isrVector), 0);
        chk("async_intDisable", 32'(intDisable), 1);
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 0;

        repeat (3000) begin
            irqAck = ($urandom_range(0, 5) == 0);
            iret   = ($urandom_range(0, 7) == 0);
            maskWr = ($urandom_range(0, 15) == 0);
            maskData = 4'($urandom);
            if ($urandom_range(0, 63) == 0) globalEn = ~globalEn;
            if ($urandom_range(0, 9) == 0) lines = 4'($urandom);
            tick();
        end
        irqAck = 0; iret = 0; maskWr = 0;
        @(negedge clk); #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
